// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with skid buffer, flush, and saturating
// stall/flush performance counters. in_ready depends only on state.
module pipe_skid_reg #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state;
  state_t            state_n;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  logic accept;
  logic take;
  logic load_main;
  logic main_from_skid;
  logic load_skid;
  logic stall_inc;
  logic flush_inc;

  // Status outputs are pure decodes of the state register.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = 2'(state);
  assign out_data  = main_q;

  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;
  assign stall_inc = out_valid & ~out_ready;
  assign flush_inc = flush & (state != EMPTY);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and payload-steering decode; flush overrides every event.
  always_comb begin
    state_n        = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_n   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && take) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_n   = FULL;
            load_skid = 1'b1;
          end else if (take) begin
            state_n = EMPTY;
          end
        end
        FULL: begin
          if (take) begin
            state_n        = ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // Payload registers; cleared on flush so an empty stage reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  // Saturating counters, evaluated on the pre-flush state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed stimulus pushes expected payloads into a
// queue; a negedge monitor pops and compares each payload taken downstream.
module tb_pipe_skid_reg;

  localparam int unsigned DW = 128;
  localparam int unsigned CW = 16;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  // Second instance with narrow counters for the saturation check.
  logic          s_flush;
  logic          s_in_valid;
  logic          s_in_ready;
  logic [7:0]    s_in_data;
  logic          s_out_valid;
  logic          s_out_ready;
  logic [7:0]    s_out_data;
  logic [1:0]    s_occupancy;
  logic [3:0]    s_stall_cnt;
  logic [3:0]    s_flush_cnt;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic [DW-1:0] exp_q[$];

  pipe_skid_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_skid_reg #(.DATA_W(8), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every downstream take must match the oldest expected payload.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL take_unexpected: got %0h expected none", out_data);
        end else begin
          chk("take_data", out_data, exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
    end
  end

  // One clock of stimulus; expectation recorded only for a real accept.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    if (v && in_ready && !fl && rst) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h0; s_out_ready = 1'b0;
    #12;
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_in_ready",  DW'(in_ready),  DW'(1));
    chk("rst_occupancy", DW'(occupancy), DW'(0));
    chk("rst_out_data",  out_data,       DW'(0));
    chk("rst_stall_cnt", DW'(stall_cnt), DW'(0));
    rst = 1'b1;

    // Single transfer: one-cycle latency, then empty again.
    step(1'b1, DW'(8'hA5), 1'b1, 1'b0);
    chk("lat_out_valid", DW'(out_valid), DW'(1));
    chk("lat_out_data",  out_data,       DW'(8'hA5));
    chk("lat_occupancy", DW'(occupancy), DW'(1));
    step(1'b0, DW'(0), 1'b1, 1'b0);
    chk("lat_drain", DW'(out_valid), DW'(0));

    // Fill both entries under backpressure, then drain in order.
    step(1'b1, DW'(8'h11), 1'b0, 1'b0);
    step(1'b1, DW'(8'h22), 1'b0, 1'b0);
    chk("full_occupancy", DW'(occupancy), DW'(2));
    chk("full_in_ready",  DW'(in_ready),  DW'(0));
    chk("full_out_data",  out_data,       DW'(8'h11));
    step(1'b0, DW'(0), 1'b1, 1'b0);
    chk("drain1_in_ready", DW'(in_ready), DW'(1));
    chk("drain1_out_data", out_data,      DW'(8'h22));
    step(1'b0, DW'(0), 1'b1, 1'b0);
    chk("drain2_out_valid", DW'(out_valid), DW'(0));
    chk("drain_stall_cnt",  DW'(stall_cnt), DW'(1));

    // Full-throughput streaming after a reset.
    pulse_reset();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0);
      chk("stream_out_data", out_data, DW'(i));
    end
    step(1'b0, DW'(0), 1'b1, 1'b0);
    chk("stream_empty", DW'(out_valid), DW'(0));
    chk("stream_stall", DW'(stall_cnt), DW'(0));

    // Fill (1 stall cycle), hold 4 more, then flush with a same-cycle push.
    pulse_reset();
    step(1'b1, DW'(8'h11), 1'b0, 1'b0);
    step(1'b1, DW'(8'h22), 1'b0, 1'b0);
    repeat (4) step(1'b0, DW'(0), 1'b0, 1'b0);
    chk("preflush_stall", DW'(stall_cnt), DW'(5));
    chk("preflush_occ",   DW'(occupancy), DW'(2));
    step(1'b1, DW'(8'h33), 1'b0, 1'b1);
    chk("flush_occ",       DW'(occupancy), DW'(0));
    chk("flush_out_data",  out_data,       DW'(0));
    chk("flush_flush_cnt", DW'(flush_cnt), DW'(1));
    chk("flush_stall_cnt", DW'(stall_cnt), DW'(6));
    step(1'b0, DW'(0), 1'b1, 1'b0);
    chk("postflush_valid", DW'(out_valid), DW'(0));
    step(1'b0, DW'(0), 1'b0, 1'b1);
    chk("empty_flush_cnt", DW'(flush_cnt), DW'(1));
    chk("empty_flush_stall", DW'(stall_cnt), DW'(6));

    // Asynchronous reset between edges while full.
    step(1'b1, DW'(8'h44), 1'b0, 1'b0);
    step(1'b1, DW'(8'h55), 1'b0, 1'b0);
    chk("pre_async_occ", DW'(occupancy), DW'(2));
    #2;
    rst = 1'b0;
    #1;
    chk("async_out_valid", DW'(out_valid), DW'(0));
    chk("async_in_ready",  DW'(in_ready),  DW'(1));
    chk("async_occ",       DW'(occupancy), DW'(0));
    chk("async_out_data",  out_data,       DW'(0));
    chk("async_flush_cnt", DW'(flush_cnt), DW'(0));
    // Inputs ignored while held in reset.
    in_valid = 1'b1; in_data = DW'(8'h77); out_ready = 1'b0; flush = 1'b1;
    @(posedge clk);
    #1;
    chk("inrst_occ",   DW'(occupancy), DW'(0));
    chk("inrst_stall", DW'(stall_cnt), DW'(0));
    chk("inrst_flush", DW'(flush_cnt), DW'(0));
    rst = 1'b1;
    step(1'b1, DW'(8'h66), 1'b1, 1'b0);
    chk("postrst_out_data", out_data, DW'(8'h66));
    step(1'b0, DW'(0), 1'b1, 1'b0);
    chk("postrst_empty", DW'(out_valid), DW'(0));

    // Narrow-counter saturation.
    s_in_valid = 1'b1; s_in_data = 8'h5A;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("sat_14", DW'(s_stall_cnt), DW'(14));
    @(posedge clk);
    #1;
    chk("sat_15", DW'(s_stall_cnt), DW'(15));
    repeat (6) @(posedge clk);
    #1;
    chk("sat_hold", DW'(s_stall_cnt), DW'(15));
    chk("sat_data", DW'(s_out_data), DW'(8'h5A));

    @(posedge clk);
    #1;
    chk("queue_empty", DW'(exp_q.size()), DW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
